md_scheduler: RTL and testbench
===============================

Name: md_scheduler

Overview:
- Multi-cycle multiply/divide sequencer for the 5-stage pipelined MIPS core (mips top).
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and owns the HI/LO registers.
- Models fixed unit latency with a countdown and raises a D-stage stall whenever a HI/LO-class instruction would otherwise issue while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; unit reset while 0
- E_start  in  1  E-stage instruction issues an md op this cycle
- E_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 reserved
- E_rs  in  32  forwarded rs operand
- E_rt  in  32  forwarded rt operand
- D_md_use  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  out  1  unit occupied by mult/div
- D_stall  out  1  stall request to the hazard unit for the D stage
- done  out  1  one-cycle pulse after HI/LO commit of a mult/div
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, count=0, hi=0, lo=0, pend_hi=0, pend_lo=0, busy=0, done=0. Applies immediately, including mid-operation: an in-flight result is discarded and HI/LO become 0.
- FSM has two states, IDLE and RUN.
- IDLE, on posedge with E_start=1:
  - op 0-3: compute result from E_rs/E_rt into pend_hi/pend_lo; count = MULT_CYCLES or DIV_CYCLES; go to RUN.
  - op 4: hi <= E_rs. op 5: lo <= E_rs. Both stay in IDLE with no busy.
  - op 6-7: no effect.
- RUN, each posedge: count decrements. When count==1 at the edge: hi <= pend_hi, lo <= pend_lo, go to IDLE, done=1 for the following cycle.
- E_start during RUN is ignored; it cannot occur legally because D_stall prevents it.
- busy = (state==RUN), registered. For a start sampled at edge k, busy is high from k through edge k+N (N cycles) and hi/lo change at edge k+N.
- D_stall = D_md_use & (busy | (E_start & E_op<=3)). Combinational; the issue cycle is covered before busy rises.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi = product[63:32], lo = product[31:0].
  - multu: same, unsigned.
  - div: signed, truncating toward zero; lo = quotient, hi = remainder, where the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - divu: unsigned.
  - Divisor zero (div or divu): pend_hi = current hi, pend_lo = current lo, so HI/LO are unchanged. Full latency and busy still apply.
- hi/lo outputs are the registers themselves; mfhi/mflo read them in E via the existing forwarding path.
- done is 0 in every cycle except the one following a commit.

Test Plan:
- mult E_rs=0xFFFFFFFD (-3), E_rt=5 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; done pulses once.
- multu 0xFFFFFFFF x 2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- div 0xFFFFFFF9 (-7) / 2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload mthi 0x12345678 and mtlo 0x9ABCDEF0, then divu by 0 -> busy for 10 cycles; hi/lo unchanged.
- mult started with D_md_use=1 in the same cycle -> D_stall=1 that cycle and for all 5 busy cycles; D_stall=0 on the cycle after commit.
- D_md_use=0 during busy -> D_stall=0.
- reset driven low at cycle 3 of a div -> busy=0, hi=lo=0 immediately; no done pulse follows.

Source files
------------

// File: rtl/md_scheduler.sv
// Multiply/divide sequencer owning HI/LO; mult/div results commit after a fixed countdown.
// Latency: MULT_CYCLES / DIV_CYCLES edges from issue to HI/LO update; mthi/mtlo take effect in one edge.
// Backpressure: combinational D_stall holds HI/LO-class instructions in D while the unit is issuing or busy.
module md_scheduler #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [2:0]  E_op,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    input  logic        D_md_use,
    output logic        busy,
    output logic        D_stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        done_q, done_d;

    logic [63:0] mul_a, mul_b, mul_prod;
    logic        div_signed, rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag, rt_safe, q_mag, r_mag, quot, rem;

    // Datapath: sign-extended 64-bit multiply, and sign-magnitude division so that
    // 0x80000000 / -1 needs no special case (magnitudes stay representable as unsigned).
    always_comb begin
        mul_a      = (E_op == OP_MULT) ? {{32{E_rs[31]}}, E_rs} : {32'd0, E_rs};
        mul_b      = (E_op == OP_MULT) ? {{32{E_rt[31]}}, E_rt} : {32'd0, E_rt};
        mul_prod   = mul_a * mul_b;
        div_signed = (E_op == OP_DIV);
        rs_neg     = div_signed & E_rs[31];
        rt_neg     = div_signed & E_rt[31];
        rs_mag     = rs_neg ? (32'd0 - E_rs) : E_rs;
        rt_mag     = rt_neg ? (32'd0 - E_rt) : E_rt;
        // Zero divisor result is discarded anyway; avoid an X-producing divide.
        rt_safe    = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
        q_mag      = rs_mag / rt_safe;
        r_mag      = rs_mag % rt_safe;
        quot       = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
        rem        = rs_neg ? (32'd0 - r_mag) : r_mag;
    end

    // Next-state: issue in IDLE, countdown and commit in RUN.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (E_start) begin
                    case (E_op)
                        OP_MULT, OP_MULTU: begin
                            pend_hi_d = mul_prod[63:32];
                            pend_lo_d = mul_prod[31:0];
                            count_d   = MULT_CNT;
                            state_d   = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero leaves HI/LO as they are but still occupies the unit.
                            if (E_rt == 32'd0) begin
                                pend_hi_d = hi_q;
                                pend_lo_d = lo_q;
                            end else begin
                                pend_hi_d = rem;
                                pend_lo_d = quot;
                            end
                            count_d = DIV_CNT;
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = E_rs;
                        OP_MTLO: lo_d = E_rs;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight result and clears HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            done_q    <= done_d;
        end
    end

    // Outputs; the stall covers the issue cycle before busy rises.
    always_comb begin
        busy    = (state_q == RUN);
        done    = done_q;
        hi      = hi_q;
        lo      = lo_q;
        D_stall = D_md_use & (busy | (E_start & (E_op <= OP_DIVU)));
    end

endmodule

// File: tb/tb_md_scheduler.sv
module tb_md_scheduler;

    logic        clk;
    logic        reset;
    logic        E_start;
    logic [2:0]  E_op;
    logic [31:0] E_rs;
    logic [31:0] E_rt;
    logic        D_md_use;
    logic        busy;
    logic        D_stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests;
    int fails;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .E_start  (E_start),
        .E_op     (E_op),
        .E_rs     (E_rs),
        .E_rt     (E_rt),
        .D_md_use (D_md_use),
        .busy     (busy),
        .D_stall  (D_stall),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one mult/div op and follow it through busy, commit and the done pulse.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic md_use, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        @(negedge clk);
        E_start  = 1'b1;
        E_op     = op;
        E_rs     = rs;
        E_rt     = rt;
        D_md_use = md_use;
        #1;
        chk({tag, "_issue_stall"}, {31'd0, D_stall}, {31'd0, md_use});
        chk({tag, "_issue_busy"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        E_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_busy_stall"}, {31'd0, D_stall}, {31'd0, md_use});
            chk({tag, "_busy_done"}, {31'd0, done}, 32'd0);
            chk({tag, "_busy_hi"}, hi, m_hi);
            chk({tag, "_busy_lo"}, lo, m_lo);
            @(posedge clk);
            #1;
        end
        chk({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_end_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_end_stall"}, {31'd0, D_stall}, 32'd0);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
        @(posedge clk);
        #1;
        chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        D_md_use = 1'b0;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        m_hi     = 32'd0;
        m_lo     = 32'd0;
        reset    = 1'b0;
        E_start  = 1'b0;
        E_op     = 3'd0;
        E_rs     = 32'd0;
        E_rt     = 32'd0;
        D_md_use = 1'b0;

        // Reset state
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", {31'd0, D_stall}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // D_md_use alone in idle does not stall
        @(negedge clk);
        D_md_use = 1'b1;
        #1;
        chk("idle_use_stall", {31'd0, D_stall}, 32'd0);
        D_md_use = 1'b0;

        // mult -3 * 5 with stall tracking
        run_op("mult", 3'd0, 32'hFFFFFFFD, 32'd5, 1'b1, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        // multu with D_md_use low: no stall while busy
        run_op("multu", 3'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 5, 32'h00000001, 32'hFFFFFFFE);
        // signed divide, negative dividend
        run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        // signed divide, negative divisor: 7 / -2 = -3 rem 1
        run_op("div_negd", 3'd2, 32'd7, 32'hFFFFFFFE, 1'b1, 10, 32'd1, 32'hFFFFFFFD);
        // overflow corner
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 32'd0, 32'h80000000);
        // unsigned divide 100 / 7 = 14 rem 2
        run_op("divu", 3'd3, 32'd100, 32'd7, 1'b0, 10, 32'd2, 32'd14);

        // mthi / mtlo: single edge, no busy, no stall even with D_md_use
        @(negedge clk);
        E_start  = 1'b1;
        E_op     = 3'd4;
        E_rs     = 32'h12345678;
        D_md_use = 1'b1;
        #1;
        chk("mthi_stall", {31'd0, D_stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        E_op = 3'd5;
        E_rs = 32'h9ABCDEF0;
        @(posedge clk);
        #1;
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi", hi, 32'h12345678);
        chk("mtlo_done", {31'd0, done}, 32'd0);
        m_hi = 32'h12345678;
        m_lo = 32'h9ABCDEF0;

        // Reserved op has no effect
        @(negedge clk);
        E_op     = 3'd6;
        E_rs     = 32'hDEADBEEF;
        D_md_use = 1'b0;
        @(posedge clk);
        #1;
        E_start = 1'b0;
        chk("rsvd_busy", {31'd0, busy}, 32'd0);
        chk("rsvd_hi", hi, 32'h12345678);
        chk("rsvd_lo", lo, 32'h9ABCDEF0);

        // divu by zero keeps HI/LO but takes full latency
        run_op("divu_zero", 3'd3, 32'd55, 32'd0, 1'b0, 10, 32'h12345678, 32'h9ABCDEF0);

        // Reset mid-div: immediate clear, no done afterwards
        @(negedge clk);
        E_start = 1'b1;
        E_op    = 3'd2;
        E_rs    = 32'd100;
        E_rt    = 32'd7;
        @(posedge clk);
        #1;
        E_start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mid_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_done", {31'd0, done}, 32'd0);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
        end

        // Unit works again after reset
        run_op("mult_after", 3'd0, 32'd3, 32'd4, 1'b1, 5, 32'd0, 32'd12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
